// File: rtl/vedic_pkg.sv
// ============================================================================
// Package   : vedic_pkg
// Purpose   : Shared widths and state encoding for the Vedic multiplier slice.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package vedic_pkg;

  localparam int SLICE_W = 16;
  localparam int PP_W    = 32;
  localparam int PROD_W  = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A1L  = 3'd1,
    A1H  = 3'd2,
    A2S0 = 3'd3,
    A2S1 = 3'd4,
    A2S2 = 3'd5,
    DONE = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/RCA16.sv
// ============================================================================
// Module    : RCA16
// Purpose   : 16-bit ripple-carry adder slice with carry in/out.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module RCA16
  import vedic_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
      assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1]  = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
  endgenerate

  assign cout = w_c[SLICE_W];

endmodule

`default_nettype wire

// File: rtl/vedic32_pp_accum.sv
// ============================================================================
// Module    : vedic32_pp_accum
// Purpose   : Combines four 16x16 partial products into a 64-bit product by
//             reusing one 16-bit adder slice over five cycles.
//             Optional macro VEDIC_ACC_OVF_CHECK_EN adds the sticky ovf flag.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module vedic32_pp_accum
  import vedic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PP_W-1:0]   q0,
  input  logic [PP_W-1:0]   q1,
  input  logic [PP_W-1:0]   q2,
  input  logic [PP_W-1:0]   q3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
`ifdef VEDIC_ACC_OVF_CHECK_EN
  ,
  output logic              ovf
`endif
);

  state_t              r_state;
  state_t              w_next;
  logic [PP_W-1:0]     r_q0, r_q1, r_q2, r_q3;
  logic [PP_W:0]       r_s1;
  logic                r_c;
  logic [PROD_W-1:0]   r_product;
  logic [SLICE_W-1:0]  w_a, w_b, w_sum;
  logic                w_cin, w_cout;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign product   = r_product;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = A1L;
      A1L:     w_next = A1H;
      A1H:     w_next = A2S0;
      A2S0:    w_next = A2S1;
      A2S1:    w_next = A2S2;
      A2S2:    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // First slice of each sum starts with cin = 0; later slices chain the carry.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    case (r_state)
      A1L:  begin w_a = r_q1[SLICE_W-1:0];    w_b = r_q2[SLICE_W-1:0]; end
      A1H:  begin w_a = r_q1[PP_W-1:SLICE_W]; w_b = r_q2[PP_W-1:SLICE_W]; w_cin = r_c; end
      A2S0: begin w_a = r_q0[PP_W-1:SLICE_W]; w_b = r_s1[SLICE_W-1:0]; end
      A2S1: begin w_a = r_q3[SLICE_W-1:0];    w_b = r_s1[PP_W-1:SLICE_W]; w_cin = r_c; end
      A2S2: begin w_a = r_q3[PP_W-1:SLICE_W]; w_b = {{(SLICE_W-1){1'b0}}, r_s1[PP_W]}; w_cin = r_c; end
      default: ;
    endcase
  end

  RCA16 u_slice (
    .a    (w_a),
    .b    (w_b),
    .cin  (w_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_q0      <= '0;
      r_q1      <= '0;
      r_q2      <= '0;
      r_q3      <= '0;
      r_s1      <= '0;
      r_c       <= 1'b0;
      r_product <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (in_valid) begin
          r_q0 <= q0;
          r_q1 <= q1;
          r_q2 <= q2;
          r_q3 <= q3;
        end
        A1L: begin
          r_s1[SLICE_W-1:0] <= w_sum;
          r_c               <= w_cout;
        end
        A1H: begin
          r_s1[PP_W-1:SLICE_W] <= w_sum;
          r_s1[PP_W]           <= w_cout;
          r_c                  <= w_cout;
        end
        A2S0: begin
          r_product[SLICE_W-1:0]         <= r_q0[SLICE_W-1:0];
          r_product[2*SLICE_W-1:SLICE_W] <= w_sum;
          r_c                            <= w_cout;
        end
        A2S1: begin
          r_product[3*SLICE_W-1:2*SLICE_W] <= w_sum;
          r_c                              <= w_cout;
        end
        A2S2: begin
          r_product[4*SLICE_W-1:3*SLICE_W] <= w_sum;
          r_c                              <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef VEDIC_ACC_OVF_CHECK_EN
  logic r_ovf;

  // A carry out of the top slice means the partial products were inconsistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == A2S2 && w_cout) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vedic32_pp_accum.sv
// ============================================================================
// Module    : tb_vedic32_pp_accum
// Purpose   : Directed self-checking bench for vedic32_pp_accum
//             (ovf checks active when VEDIC_ACC_OVF_CHECK_EN is defined).
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vedic32_pp_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] q0, q1, q2, q3;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [63:0] product;
`ifdef VEDIC_ACC_OVF_CHECK_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vedic32_pp_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
`ifdef VEDIC_ACC_OVF_CHECK_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one set, then scramble the bus so only the captured copy matters.
  task automatic handshake(input logic [31:0] a0, a1, a2, a3);
    @(negedge clk);
    q0 = a0; q1 = a1; q2 = a2; q3 = a3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    q0 = 32'hA5A5_A5A5; q1 = 32'h5A5A_5A5A; q2 = 32'hC3C3_C3C3; q3 = 32'h3C3C_3C3C;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_txn(input string tag, input logic [31:0] a0, a1, a2, a3,
                         input logic [63:0] exp);
    int cyc;
    handshake(a0, a1, a2, a3);
    check_value({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(cyc);
    check_value({tag, "_lat"}, 64'(cyc), 64'd5);
    check_value({tag, "_prod"}, product, exp);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_value({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    check_value({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] expq[$];
    logic [31:0] ra, rb;
    int          cyc, last, nres;
    bit          saw_valid;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    q0 = '0; q1 = '0; q2 = '0; q3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("rst_in_ready", 64'(in_ready), 64'd0);
    check_value("rst_out_valid", 64'(out_valid), 64'd0);
    check_value("rst_busy", 64'(busy), 64'd0);
    check_value("rst_product", product, 64'd0);
`ifdef VEDIC_ACC_OVF_CHECK_EN
    check_value("rst_ovf", 64'(ovf), 64'd0);
`endif
    rst = 1'b0;
    #1;
    check_value("post_rst_in_ready", 64'(in_ready), 64'd1);

    run_txn("allones", 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001,
            64'hFFFF_FFFE_0000_0001);

    // out_ready high before DONE must not disturb the computation.
    out_ready = 1'b1;
    run_txn("q0only", 32'd1, 32'd0, 32'd0, 32'd0, 64'h0000_0000_0000_0001);
    run_txn("q3only", 32'd0, 32'd0, 32'd0, 32'd1, 64'h0000_0001_0000_0000);

    // A = 0x00020003, B = 0x00040005 held under backpressure.
    handshake(32'd15, 32'd10, 32'd12, 32'd8);
    wait_done(cyc);
    check_value("bp_lat", 64'(cyc), 64'd5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      q0 = 32'h1234_5678 + 32'(i);
      @(posedge clk);
      #1;
      check_value("bp_prod", product, 64'h0000_0008_0016_000F);
      check_value("bp_valid", 64'(out_valid), 64'd1);
      check_value("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_value("bp_release_valid", 64'(out_valid), 64'd0);
    check_value("bp_release_ready", 64'(in_ready), 64'd1);

    // Reset while in A2S0 abandons the computation.
    handshake(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    repeat (2) begin @(posedge clk); #1; end
    check_value("midrst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_value("midrst_valid", 64'(out_valid), 64'd0);
    check_value("midrst_product", product, 64'd0);
    check_value("midrst_busy_cleared", 64'(busy), 64'd0);
    check_value("midrst_in_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("midrst_in_ready", 64'(in_ready), 64'd1);
    saw_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) saw_valid = 1'b1; end
    check_value("midrst_no_emit", 64'(saw_valid), 64'd0);
    run_txn("q1shift", 32'd0, 32'h0001_0000, 32'd0, 32'd0, 64'h0000_0001_0000_0000);

    // Back-to-back: in_valid stays high with fresh data every cycle.
    last = -1; nres = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (expq.size() == 0) check_value("b2b_unexpected", 64'd1, 64'd0);
        else check_value("b2b_prod", product, expq.pop_front());
        if (last >= 0) check_value("b2b_gap", 64'(c - last), 64'd7);
        last = c;
        nres++;
      end
      ra = $urandom; rb = $urandom;
      q0 = ra[15:0]  * rb[15:0];
      q1 = ra[31:16] * rb[15:0];
      q2 = ra[15:0]  * rb[31:16];
      q3 = ra[31:16] * rb[31:16];
      if (in_ready) expq.push_back({32'd0, ra} * {32'd0, rb});
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_value("b2b_count", 64'(nres >= 4), 64'd1);
    wait_done(cyc);
    if (expq.size() == 0) check_value("b2b_drain_expect", 64'd1, 64'd0);
    else check_value("b2b_drain_prod", product, expq.pop_front());
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_value("b2b_idle", 64'(busy), 64'd0);

`ifdef VEDIC_ACC_OVF_CHECK_EN
    check_value("ovf_before", 64'(ovf), 64'd0);
    run_txn("illegal", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            64'h0001_FFFF_FFFD_FFFF);
    check_value("ovf_set", 64'(ovf), 64'd1);
    run_txn("legal_after", 32'd1, 32'd0, 32'd0, 32'd0, 64'd1);
    check_value("ovf_sticky", 64'(ovf), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_value("ovf_cleared", 64'(ovf), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
